// File: rtl/common_fifo_buffer.sv
// First-word fall-through FIFO with valid/ready on both sides.
// Wrap-bit pointers give full/empty without a separate counter.
module common_fifo_buffer #(
  parameter int BUFFER_WIDTH = 1,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [BUFFER_WIDTH-1:0]         prev_i_data,
  input  logic                            prev_i_valid,
  output logic                            prev_o_ready,
  output logic [BUFFER_WIDTH-1:0]         next_o_data,
  output logic                            next_o_valid,
  input  logic                            next_i_ready,
  output logic [$clog2(BUFFER_DEPTH):0]   o_count
);

  localparam int IDX_W = $clog2(BUFFER_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [PTR_W-1:0]        rptr_q, rptr_d;
  logic [BUFFER_WIDTH-1:0] mem_q [BUFFER_DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
            (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);

    // Ready depends only on our own state, so a full buffer cannot accept
    // in the same cycle it is drained.
    prev_o_ready = reset & ~full;
    next_o_valid = reset & ~empty;
    next_o_data  = mem_q[rptr_q[IDX_W-1:0]];
    o_count      = reset ? (wptr_q - rptr_q) : '0;

    push = prev_i_valid & prev_o_ready;
    pop  = next_o_valid & next_i_ready;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once
  // written, and resetting the pointers is enough to discard them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[IDX_W-1:0]] <= prev_i_data;
  end

endmodule

// File: tb/tb_common_fifo_buffer.sv
// Self-checking bench for common_fifo_buffer: directed scenarios plus random
// backpressure, all checked against a queue model of the FIFO.
module tb_common_fifo_buffer;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] prev_i_data;
  logic         prev_i_valid;
  logic         prev_o_ready;
  logic [W-1:0] next_o_data;
  logic         next_o_valid;
  logic         next_i_ready;
  logic [2:0]   o_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_q [$];

  common_fifo_buffer #(.BUFFER_WIDTH(W), .BUFFER_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .prev_i_data  (prev_i_data),
    .prev_i_valid (prev_i_valid),
    .prev_o_ready (prev_o_ready),
    .next_o_data  (next_o_data),
    .next_o_valid (next_o_valid),
    .next_i_ready (next_i_ready),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Outputs are checked
  // mid-cycle against the model, then the model applies the handshake rules.
  task automatic cycle(input logic rst, input logic v, input logic [W-1:0] d, input logic r);
    logic exp_ready, exp_valid;
    reset        = rst;
    prev_i_valid = v;
    prev_i_data  = d;
    next_i_ready = r;
    #1;
    exp_ready = rst && (model_q.size() < DEPTH);
    exp_valid = rst && (model_q.size() > 0);
    check("prev_o_ready", 32'(prev_o_ready), 32'(exp_ready));
    check("next_o_valid", 32'(next_o_valid), 32'(exp_valid));
    check("o_count", 32'(o_count), rst ? 32'(model_q.size()) : 32'd0);
    if (exp_valid) check("next_o_data", 32'(next_o_data), 32'(model_q[0]));
    @(posedge clk);
    if (!rst) model_q.delete();
    else begin
      if (exp_valid && r) void'(model_q.pop_front());
      if (v && exp_ready) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b0;
    prev_i_valid = 1'b0;
    prev_i_data  = '0;
    next_i_ready = 1'b0;
    @(negedge clk);

    // Reset held with valid asserted, then release.
    repeat (3) cycle(1'b0, 1'b1, 8'h11, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Fall-through: push 0xA5 with downstream ready.
    cycle(1'b1, 1'b1, 8'hA5, 1'b1);
    #1;
    check("ft_valid", 32'(next_o_valid), 32'd1);
    check("ft_data", 32'(next_o_data), 32'hA5);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    #1;
    check("ft_drained_count", 32'(o_count), 32'd0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Fill to full, then pop while pushing 5.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, W'(i), 1'b0);
    #1;
    check("full_count", 32'(o_count), 32'd4);
    check("full_ready", 32'(prev_o_ready), 32'd0);
    cycle(1'b1, 1'b1, 8'd5, 1'b1);
    #1;
    check("after_pop_count", 32'(o_count), 32'd3);
    check("after_pop_head", 32'(next_o_data), 32'd2);
    cycle(1'b1, 1'b1, 8'd5, 1'b0);
    #1;
    check("late_push_count", 32'(o_count), 32'd4);
    repeat (5) cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Wrap-around at full throughput.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, W'(i), 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Random backpressure.
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
      check("count_range", 32'(o_count <= 3'(DEPTH)), 32'd1);
    end
    repeat (6) cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Mid-operation reset with three entries buffered.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, W'(8'h70 + i), 1'b0);
    #1;
    check("pre_reset_count", 32'(o_count), 32'd3);
    cycle(1'b0, 1'b1, 8'hEE, 1'b1);
    #1;
    check("post_reset_count", 32'(o_count), 32'd0);
    check("post_reset_valid", 32'(next_o_valid), 32'd0);
    cycle(1'b1, 1'b1, 8'h3C, 1'b0);
    #1;
    check("first_after_reset", 32'(next_o_data), 32'h3C);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
